// File: rtl/dmem_mmio_responder.sv
// dmem_mmio_responder: word-addressed data RAM plus MMIO TX FIFO, status/control and cycle counter
module dmem_mmio_responder #(
  parameter int RAM_AW     = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int FIFO_AW    = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [31:0] aluoutm,
  input  logic [31:0] writedatam,
  input  logic        memwritem,
  output logic [31:0] readdatam,
  output logic [31:0] tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        overflow
);
  logic [31:0]        ram_q [2**RAM_AW];
  logic [31:0]        fifo_q [FIFO_DEPTH];
  logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW:0]   count_q, count_d;
  logic               overflow_q, overflow_d;
  logic [31:0]        cycle_q, cycle_d;
  logic               is_mmio, ram_we, tx_we, st_we, cy_we;
  logic               full, empty, pop, push;
  logic [1:0]         off;
  logic [RAM_AW-1:0]  ram_idx;
  logic [31:0]        status;
  logic               unused_addr;
  assign unused_addr = ^{aluoutm[30:RAM_AW+2], aluoutm[1:0]};
  always_comb begin
    is_mmio    = aluoutm[31];
    off        = aluoutm[3:2];
    ram_idx    = aluoutm[RAM_AW+1:2];
    ram_we     = memwritem & ~is_mmio & ~reset;
    tx_we      = memwritem & is_mmio & (off == 2'd0);
    st_we      = memwritem & is_mmio & (off == 2'd1);
    cy_we      = memwritem & is_mmio & (off == 2'd2);
    full       = count_q == (FIFO_AW+1)'(FIFO_DEPTH);
    empty      = count_q == '0;
    pop        = ~empty & tx_ready;
    push       = tx_we & (~full | pop);
    rd_ptr_d   = reset ? '0 : pop ? rd_ptr_q + FIFO_AW'(1) : rd_ptr_q;
    wr_ptr_d   = reset ? '0 : push ? wr_ptr_q + FIFO_AW'(1) : wr_ptr_q;
    count_d    = reset ? '0 :
                 (push & ~pop) ? count_q + (FIFO_AW+1)'(1) :
                 (pop & ~push) ? count_q - (FIFO_AW+1)'(1) : count_q;
    overflow_d = reset ? 1'b0 :
                 (tx_we & ~push) ? 1'b1 :
                 (st_we & writedatam[15]) ? 1'b0 : overflow_q;
    cycle_d    = reset ? '0 : cy_we ? writedatam : en ? cycle_q + 32'd1 : cycle_q;
    status     = {16'b0, overflow_q, full, empty, 5'b0, {(7-FIFO_AW){1'b0}}, count_q};
    readdatam  = ~is_mmio ? ram_q[ram_idx] :
                 (off == 2'd1) ? status :
                 (off == 2'd2) ? cycle_q : 32'd0;
  end
  assign tx_data  = fifo_q[rd_ptr_q];
  assign tx_valid = ~empty;
  assign overflow = overflow_q;
  always_ff @(posedge clk) begin
    rd_ptr_q   <= rd_ptr_d;
    wr_ptr_q   <= wr_ptr_d;
    count_q    <= count_d;
    overflow_q <= overflow_d;
    cycle_q    <= cycle_d;
    if (reset) fifo_q[0] <= '0;
    else if (push) fifo_q[wr_ptr_q] <= writedatam;
  end
  always_ff @(posedge clk) begin
    if (ram_we) ram_q[ram_idx] <= writedatam;
  end
endmodule

// File: tb/tb_dmem_mmio_responder.sv
// tb_dmem_mmio_responder: directed vectors for RAM, TX FIFO, status and cycle counter
module tb_dmem_mmio_responder;
  localparam logic [31:0] TXD = 32'h8000_0000, STS = 32'h8000_0004,
                          CYC = 32'h8000_0008, RSV = 32'h8000_000C;
  logic        clk = 0, reset = 1, en = 0, memwritem = 0, tx_ready = 0;
  logic [31:0] aluoutm = 0, writedatam = 0;
  logic [31:0] readdatam, tx_data;
  logic        tx_valid, overflow;
  int          n_cmp = 0, n_bad = 0;
  dmem_mmio_responder dut (
    .clk(clk), .reset(reset), .en(en), .aluoutm(aluoutm), .writedatam(writedatam),
    .memwritem(memwritem), .readdatam(readdatam), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .overflow(overflow)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic store(input logic [31:0] a, input logic [31:0] d);
    aluoutm = a; writedatam = d; memwritem = 1;
    tick();
    memwritem = 0;
  endtask
  task automatic load_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    aluoutm = a;
    #1;
    check(tag, readdatam, exp);
  endtask
  initial begin
    tick(); tick();
    reset = 0;
    check("rst_valid", {31'b0, tx_valid}, 0);
    check("rst_ovf", {31'b0, overflow}, 0);
    check("rst_txdata", tx_data, 0);
    load_chk("rst_status", STS, 32'h0000_2000);
    load_chk("rst_cycle", CYC, 0);
    // RAM: store then load, alias, and old value during a same-word store
    store(32'h10, 32'hDEAD_BEEF);
    load_chk("ram_rd", 32'h10, 32'hDEAD_BEEF);
    load_chk("ram_alias", 32'h410, 32'hDEAD_BEEF);
    aluoutm = 32'h10; writedatam = 32'h1234_5678; memwritem = 1;
    #1 check("ram_old", readdatam, 32'hDEAD_BEEF);
    tick(); memwritem = 0;
    load_chk("ram_new", 32'h10, 32'h1234_5678);
    // FIFO fill, overflow, drain
    for (int i = 1; i <= 8; i++) store(TXD, i);
    load_chk("fill_status", STS, 32'h0000_4008);
    load_chk("txd_load", TXD, 0);
    check("fill_head", tx_data, 1);
    store(TXD, 9);
    check("ovf_set", {31'b0, overflow}, 1);
    load_chk("ovf_status", STS, 32'h0000_C008);
    tx_ready = 1;
    for (int i = 1; i <= 8; i++) begin
      check($sformatf("drain_data%0d", i), tx_data, i);
      check($sformatf("drain_valid%0d", i), {31'b0, tx_valid}, 1);
      tick();
    end
    tx_ready = 0;
    check("drained_valid", {31'b0, tx_valid}, 0);
    load_chk("drained_status", STS, 32'h0000_A000);
    // overflow clear only with bit 15; reserved offset inert
    store(STS, 0);
    load_chk("clr_noop", STS, 32'h0000_A000);
    store(RSV, 32'hFFFF_FFFF);
    load_chk("rsv_load", RSV, 0);
    load_chk("rsv_noeff", STS, 32'h0000_A000);
    store(STS, 32'h0000_8000);
    load_chk("clr_status", STS, 32'h0000_2000);
    check("clr_ovf", {31'b0, overflow}, 0);
    // full with simultaneous push and pop
    for (int i = 0; i < 8; i++) store(TXD, 32'h11 + i);
    tx_ready = 1;
    store(TXD, 32'hAA);
    tx_ready = 0;
    load_chk("fullpp_status", STS, 32'h0000_4008);
    check("fullpp_ovf", {31'b0, overflow}, 0);
    tx_ready = 1;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("fullpp_data%0d", i), tx_data, (i == 7) ? 32'hAA : 32'h12 + i);
      tick();
    end
    tx_ready = 0;
    check("fullpp_empty", {31'b0, tx_valid}, 0);
    // cycle counter: store priority, wrap, hold
    en = 1;
    store(CYC, 32'hFFFF_FFFE);
    load_chk("cyc_ld", CYC, 32'hFFFF_FFFE);
    tick(); load_chk("cyc_max", CYC, 32'hFFFF_FFFF);
    tick(); load_chk("cyc_wrap", CYC, 0);
    tick(); load_chk("cyc_one", CYC, 1);
    en = 0;
    tick(); tick(); load_chk("cyc_hold", CYC, 1);
    // reset mid-operation
    for (int i = 0; i < 3; i++) store(TXD, 32'hC0 + i);
    store(CYC, 32'h100);
    store(32'h20, 32'hCAFE_F00D);
    load_chk("pre_status", STS, 32'h0000_0003);
    reset = 1; aluoutm = TXD; writedatam = 32'h55; memwritem = 1;
    tick();
    reset = 0; memwritem = 0;
    check("mid_valid", {31'b0, tx_valid}, 0);
    check("mid_txdata", tx_data, 0);
    load_chk("mid_status", STS, 32'h0000_2000);
    load_chk("mid_cycle", CYC, 0);
    load_chk("mid_ram10", 32'h10, 32'h1234_5678);
    load_chk("mid_ram20", 32'h20, 32'hCAFE_F00D);
    // no fall-through on push into empty FIFO
    aluoutm = TXD; writedatam = 32'h77; memwritem = 1;
    #1 check("nofall_valid", {31'b0, tx_valid}, 0);
    tick(); memwritem = 0;
    check("push_valid", {31'b0, tx_valid}, 1);
    check("push_data", tx_data, 32'h77);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
